// File: rtl/seg_pkg.sv
// Shared types, constants and hex-to-segment table for the 7-segment scan controller.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned HEX_W      = 4;
    localparam int unsigned SEG_W      = 8;

    localparam logic [SEG_W-1:0] SEG_OFF = 8'h00;
    localparam logic [SEG_W-1:0] COM_OFF = 8'hFF;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } state_t;

    // One stored digit: decimal point plus hex nibble.
    typedef struct packed {
        logic             dp;
        logic [HEX_W-1:0] hex;
    } digit_t;

    // Hex nibble to {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [HEX_W-1:0] hex);
        logic [6:0] seg;
        seg = 7'h00;
        case (hex)
            4'h0: seg = 7'h3f;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5b;
            4'h3: seg = 7'h4f;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6d;
            4'h6: seg = 7'h7d;
            4'h7: seg = 7'h27;
            4'h8: seg = 7'h7f;
            4'h9: seg = 7'h6f;
            4'ha: seg = 7'h5f;
            4'hb: seg = 7'h7c;
            4'hc: seg = 7'h58;
            4'hd: seg = 7'h5e;
            4'he: seg = 7'h7b;
            4'hf: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex_decode.sv
// Combinational hex nibble to 7-segment pattern decoder.
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [HEX_W-1:0] hex,
    output logic [6:0]       seg_c
);

    // Table lookup shared with the package.
    assign seg_c = hex_to_seg(hex);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 8-digit 7-segment scan controller with inter-digit blanking.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter logic [15:0] DIV       = 16'd50000,
    parameter logic [7:0]  BLANK_CYC = 8'd100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_addr,
    input  logic [4:0]       wr_data,
    input  logic [7:0]       digit_en,
    input  logic             blank,
    output logic [SEG_W-1:0] seg_d,
    output logic [SEG_W-1:0] seg_com,
    output logic             frame_tick
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(DIV) - CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC) - CNT_W'(1);

    digit_t           digit_q [NUM_DIGITS];
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic [SEG_W-1:0] slot_d, slot_d_nxt;
    logic [SEG_W-1:0] slot_com, slot_com_nxt;
    logic             tick_nxt;
    digit_t           cur_c;
    logic [6:0]       cur_seg_c;

    assign cur_c = digit_q[idx];

    seg_hex_decode u_dec (
        .hex   (cur_c.hex),
        .seg_c (cur_seg_c)
    );

    // Host-written digit registers; writes land in any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= '0;
            end
        end else if (wr_en) begin
            digit_q[wr_addr] <= digit_t'(wr_data);
        end
    end

    // State, slot counter, digit index, slot snapshot and pin registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= BLANK;
            cnt        <= '0;
            idx        <= '0;
            slot_d     <= SEG_OFF;
            slot_com   <= COM_OFF;
            seg_d      <= SEG_OFF;
            seg_com    <= COM_OFF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            idx        <= idx_nxt;
            slot_d     <= slot_d_nxt;
            slot_com   <= slot_com_nxt;
            seg_d      <= blank ? SEG_OFF : slot_d_nxt;
            seg_com    <= blank ? COM_OFF : slot_com_nxt;
            frame_tick <= tick_nxt;
        end
    end

    // Next-state logic; the slot snapshot is captured only on SHOW entry.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_W'(1);
        idx_nxt      = idx;
        slot_d_nxt   = slot_d;
        slot_com_nxt = slot_com;
        tick_nxt     = 1'b0;
        case (state)
            BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                    if (digit_en[idx]) begin
                        slot_d_nxt   = {cur_c.dp, cur_seg_c};
                        slot_com_nxt = ~(SEG_W'(1) << idx);
                    end else begin
                        slot_d_nxt   = SEG_OFF;
                        slot_com_nxt = COM_OFF;
                    end
                end
            end
            SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_nxt    = BLANK;
                    cnt_nxt      = '0;
                    idx_nxt      = idx + IDX_W'(1);
                    slot_d_nxt   = SEG_OFF;
                    slot_com_nxt = COM_OFF;
                    tick_nxt     = (idx == IDX_W'(NUM_DIGITS - 1));
                end
            end
            default: begin
                state_nxt = BLANK;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: directed tables plus random traffic against a timing model.
module tb_seg_scan_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned B = 2;
    localparam int unsigned S = D + B;
    localparam int unsigned F = 8 * S;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] digit_en;
    logic       blank;
    logic [7:0] seg_d;
    logic [7:0] seg_com;
    logic       frame_tick;

    seg_scan_ctrl #(
        .DIV       (16'(D)),
        .BLANK_CYC (8'(B))
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .digit_en   (digit_en),
        .blank      (blank),
        .seg_d      (seg_d),
        .seg_com    (seg_com),
        .frame_tick (frame_tick)
    );

    typedef struct packed {
        logic [31:0] t;
        logic [7:0]  d;
        logic [7:0]  com;
        logic        tick;
    } vec_t;

    typedef struct packed {
        logic [4:0] w;
        logic [7:0] d;
        logic [7:0] com;
    } dvec_t;

    int unsigned n_pass;
    int unsigned n_total;
    int unsigned t;
    logic [4:0]  m_regs [8];
    logic [6:0]  seg_tab [16];
    logic [7:0]  m_snap_d, m_snap_com, exp_d, exp_com;
    logic        exp_tick;
    vec_t        v1 [$];
    dvec_t       dv [$];
    vec_t        v3 [$];
    int unsigned base;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s t=%0d got %02h want %02h", name, t, act, exp);
    endfunction

    function automatic void chk_v(input string name, input logic [7:0] d, input logic [7:0] com,
                                  input logic tick);
        chk({name, ".seg_d"}, seg_d, d);
        chk({name, ".seg_com"}, seg_com, com);
        chk({name, ".frame_tick"}, 8'(frame_tick), 8'(tick));
    endfunction

    function automatic void model_reset();
        t = 0;
        for (int i = 0; i < 8; i++) m_regs[i] = 5'h00;
        m_snap_d   = 8'h00;
        m_snap_com = 8'hFF;
        exp_d      = 8'h00;
        exp_com    = 8'hFF;
        exp_tick   = 1'b0;
    endfunction

    // Timing derived from absolute edge number since reset release.
    function automatic void model_edge();
        int unsigned u;
        int unsigned k;
        int unsigned o;
        logic        showing;
        t++;
        exp_tick = (t % F == 0);
        showing  = 1'b0;
        if (t >= B) begin
            u = (t - B) % F;
            k = u / S;
            o = u % S;
            if (o == 0) begin
                if (digit_en[k]) begin
                    m_snap_d   = {m_regs[k][4], seg_tab[m_regs[k][3:0]]};
                    m_snap_com = ~(8'h01 << k);
                end else begin
                    m_snap_d   = 8'h00;
                    m_snap_com = 8'hFF;
                end
            end
            showing = (o < D);
        end
        exp_d   = (showing && !blank) ? m_snap_d : 8'h00;
        exp_com = (showing && !blank) ? m_snap_com : 8'hFF;
        if (wr_en) m_regs[wr_addr] = wr_data;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst) model_edge();
        else model_reset();
        @(negedge clk);
        chk("model.seg_d", seg_d, exp_d);
        chk("model.seg_com", seg_com, exp_com);
        chk("model.frame_tick", 8'(frame_tick), 8'(exp_tick));
    endtask

    task automatic goto(input int unsigned target);
        while (t < target) cyc();
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] v);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = v;
        cyc();
        wr_en   = 1'b0;
    endtask

    function automatic int unsigned next_frame();
        return ((t / F) + 1) * F;
    endfunction

    initial begin
        seg_tab = '{7'h3f, 7'h06, 7'h5b, 7'h4f, 7'h66, 7'h6d, 7'h7d, 7'h27,
                    7'h7f, 7'h6f, 7'h5f, 7'h7c, 7'h58, 7'h5e, 7'h7b, 7'h71};
        n_pass  = 0;
        n_total = 0;
        base    = 0;

        // Single lit digit 0 holding 5'h15 -> ED.
        v1.push_back({32'd1,  8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd2,  8'hED, 8'hFE, 1'b0});
        v1.push_back({32'd3,  8'hED, 8'hFE, 1'b0});
        v1.push_back({32'd5,  8'hED, 8'hFE, 1'b0});
        v1.push_back({32'd6,  8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd7,  8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd8,  8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd11, 8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd20, 8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd47, 8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd48, 8'h00, 8'hFF, 1'b1});
        v1.push_back({32'd49, 8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd50, 8'hED, 8'hFE, 1'b0});
        v1.push_back({32'd53, 8'hED, 8'hFE, 1'b0});
        v1.push_back({32'd54, 8'h00, 8'hFF, 1'b0});
        v1.push_back({32'd96, 8'h00, 8'hFF, 1'b1});
        v1.push_back({32'd98, 8'hED, 8'hFE, 1'b0});

        // Decode table across two frames: {write value, seg_d, seg_com}.
        dv.push_back({5'h00, 8'h3f, 8'hFE});
        dv.push_back({5'h01, 8'h06, 8'hFD});
        dv.push_back({5'h02, 8'h5b, 8'hFB});
        dv.push_back({5'h03, 8'h4f, 8'hF7});
        dv.push_back({5'h04, 8'h66, 8'hEF});
        dv.push_back({5'h05, 8'h6d, 8'hDF});
        dv.push_back({5'h06, 8'h7d, 8'hBF});
        dv.push_back({5'h07, 8'h27, 8'h7F});
        dv.push_back({5'h08, 8'h7f, 8'hFE});
        dv.push_back({5'h19, 8'hEF, 8'hFD});
        dv.push_back({5'h0A, 8'h5f, 8'hFB});
        dv.push_back({5'h1B, 8'hFC, 8'hF7});
        dv.push_back({5'h0C, 8'h58, 8'hEF});
        dv.push_back({5'h1D, 8'hDE, 8'hDF});
        dv.push_back({5'h0E, 8'h7b, 8'hBF});
        dv.push_back({5'h1F, 8'hF1, 8'h7F});

        // digit_en = 0A with frame-B register contents; t holds the slot number.
        v3.push_back({32'd0, 8'h00, 8'hFF, 1'b0});
        v3.push_back({32'd1, 8'hEF, 8'hFD, 1'b0});
        v3.push_back({32'd2, 8'h00, 8'hFF, 1'b0});
        v3.push_back({32'd3, 8'hFC, 8'hF7, 1'b0});
        v3.push_back({32'd4, 8'h00, 8'hFF, 1'b0});
        v3.push_back({32'd5, 8'h00, 8'hFF, 1'b0});
        v3.push_back({32'd6, 8'h00, 8'hFF, 1'b0});
        v3.push_back({32'd7, 8'h00, 8'hFF, 1'b0});

        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 3'd0;
        wr_data  = 5'd0;
        digit_en = 8'h00;
        blank    = 1'b0;
        model_reset();
        #1 rst = 1'b0;

        // Reset held with random inputs.
        for (int i = 0; i < 6; i++) begin
            wr_en    = 1'($urandom);
            wr_addr  = 3'($urandom);
            wr_data  = 5'($urandom);
            digit_en = 8'($urandom);
            blank    = 1'($urandom);
            cyc();
            chk_v("reset_hold", 8'h00, 8'hFF, 1'b0);
        end

        // Release and write digit 0 on the first edge.
        wr_en    = 1'b0;
        blank    = 1'b0;
        digit_en = 8'h01;
        rst      = 1'b1;
        wr(3'd0, 5'h15);
        foreach (v1[i]) begin
            goto(int'(v1[i].t));
            chk_v("single_digit", v1[i].d, v1[i].com, v1[i].tick);
        end

        // Full decode table, all digits enabled.
        digit_en = 8'hFF;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 8; k++) wr(3'(k), dv[f*8+k].w);
            base = next_frame();
            for (int k = 0; k < 8; k++) begin
                goto(base + B + S * k);
                chk_v("decode_scan", dv[f*8+k].d, dv[f*8+k].com, 1'b0);
            end
            goto(base + F);
            chk_v("frame_tick", 8'h00, 8'hFF, 1'b1);
        end

        // Sparse enable keeps frame period.
        digit_en = 8'h0A;
        base = next_frame();
        foreach (v3[i]) begin
            goto(base + B + S * int'(v3[i].t) + 1);
            chk_v("sparse_en", v3[i].d, v3[i].com, v3[i].tick);
        end
        goto(base + F - 1);
        chk_v("sparse_tick_pre", 8'h00, 8'hFF, 1'b0);
        goto(base + F);
        chk_v("sparse_tick", 8'h00, 8'hFF, 1'b1);

        // Write to the digit currently shown does not disturb its slot.
        digit_en = 8'hFF;
        base = next_frame();
        goto(base + 14);
        chk_v("live_write_before", 8'h5f, 8'hFB, 1'b0);
        wr(3'd2, 5'h0F);
        chk_v("live_write_same", 8'h5f, 8'hFB, 1'b0);
        goto(base + 17);
        chk_v("live_write_end", 8'h5f, 8'hFB, 1'b0);
        goto(base + 18);
        chk_v("live_write_gap", 8'h00, 8'hFF, 1'b0);
        goto(base + F + 14);
        chk_v("live_write_next", 8'h71, 8'hFB, 1'b0);

        // Global blank for 10 cycles mid-frame, release mid-slot.
        base = next_frame();
        goto(base + 11);
        chk_v("blank_pre", 8'hEF, 8'hFD, 1'b0);
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_v("blank_on", 8'h00, 8'hFF, 1'b0);
        end
        blank = 1'b0;
        cyc();
        chk_v("blank_resume", 8'hFC, 8'hF7, 1'b0);
        cyc();
        chk_v("blank_resume2", 8'hFC, 8'hF7, 1'b0);
        goto(base + 24);
        chk_v("blank_gap", 8'h00, 8'hFF, 1'b0);
        goto(base + F);
        chk_v("blank_tick", 8'h00, 8'hFF, 1'b1);
        goto(base + F + 2);
        chk_v("blank_next_frame", 8'h7f, 8'hFE, 1'b0);

        // Random traffic against the model.
        for (int i = 0; i < 700; i++) begin
            wr_en   = ($urandom_range(0, 2) == 0);
            wr_addr = 3'($urandom);
            wr_data = 5'($urandom);
            if ($urandom_range(0, 11) == 0) digit_en = 8'($urandom);
            if ($urandom_range(0, 19) == 0) blank = ~blank;
            cyc();
        end

        // Asynchronous reset mid-SHOW.
        wr_en    = 1'b0;
        blank    = 1'b0;
        digit_en = 8'hFF;
        base = next_frame();
        goto(base + 3);
        chk("pre_reset.seg_com", seg_com, 8'hFE);
        #2 rst = 1'b0;
        #1;
        chk_v("async_reset", 8'h00, 8'hFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'($urandom);
            wr_addr = 3'($urandom);
            wr_data = 5'($urandom);
            cyc();
        end
        wr_en = 1'b0;
        rst   = 1'b1;
        goto(2);
        chk_v("restart_digit0", 8'h3f, 8'hFE, 1'b0);
        goto(F);
        chk_v("restart_tick", 8'h00, 8'hFF, 1'b1);
        goto(F + S + 2);
        chk_v("restart_digit1", 8'h3f, 8'hFD, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
